// File: rtl/spart_driver.sv
// Bus-side controller for the SPART: programs the baud divisor from br_cfg, then echoes received bytes.
// Optional feature macro SPART_DRV_UPPERCASE_EN: echo lowercase ASCII as uppercase.
module spart_driver #(
  parameter logic [15:0] DIV0 = 16'h028A,
  parameter logic [15:0] DIV1 = 16'h0144,
  parameter logic [15:0] DIV2 = 16'h00A2,
  parameter logic [15:0] DIV3 = 16'h0050
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] br_cfg,
  input  logic       rda,
  input  logic       tbr,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic [7:0] last_byte,
  output logic [7:0] echo_cnt
);

  typedef enum logic [2:0] {CFG_LO, CFG_HI, IDLE, READ, WAIT_TBR, WRITE} state_t;

  state_t     state_q, state_d;
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] cur_cfg_q, cur_cfg_d;
  logic [1:0] sel_cfg_q, sel_cfg_d;
  logic       cfg_pend_q, cfg_pend_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic [7:0] last_byte_q, last_byte_d;
  logic [7:0] echo_cnt_q, echo_cnt_d;
  logic [15:0] div_sel;
  logic [7:0] echo_byte;
  logic [7:0] dout;
  logic       drive;

  function automatic logic [15:0] divisor(input logic [1:0] cfg);
    case (cfg)
      2'b00:   divisor = DIV0;
      2'b01:   divisor = DIV1;
      2'b10:   divisor = DIV2;
      default: divisor = DIV3;
    endcase
  endfunction

  function automatic logic [7:0] convert(input logic [7:0] b);
`ifdef SPART_DRV_UPPERCASE_EN
    if (b >= 8'h61 && b <= 8'h7A) convert = b - 8'h20;
    else                          convert = b;
`else
    convert = b;
`endif
  endfunction

  assign div_sel   = divisor(sel_cfg_q);
  assign echo_byte = convert(rx_byte_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CFG_LO;
      sync1_q     <= 2'b00;
      sync2_q     <= 2'b00;
      cur_cfg_q   <= 2'b00;
      sel_cfg_q   <= 2'b00;
      cfg_pend_q  <= 1'b0;
      rx_byte_q   <= 8'h00;
      last_byte_q <= 8'h00;
      echo_cnt_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      sync1_q     <= br_cfg;
      sync2_q     <= sync1_q;
      cur_cfg_q   <= cur_cfg_d;
      sel_cfg_q   <= sel_cfg_d;
      cfg_pend_q  <= cfg_pend_d;
      rx_byte_q   <= rx_byte_d;
      last_byte_q <= last_byte_d;
      echo_cnt_q  <= echo_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_cfg_d   = cur_cfg_q;
    sel_cfg_d   = sel_cfg_q;
    cfg_pend_d  = (sync2_q != cur_cfg_q);
    rx_byte_d   = rx_byte_q;
    last_byte_d = last_byte_q;
    echo_cnt_d  = echo_cnt_q;
    case (state_q)
      CFG_LO: state_d = CFG_HI;
      CFG_HI: begin
        cur_cfg_d  = sel_cfg_q;
        cfg_pend_d = 1'b0;
        state_d    = IDLE;
      end
      IDLE: begin
        // Reconfiguration wins over a waiting byte; divisor choice is frozen here.
        if (cfg_pend_q) begin
          sel_cfg_d = sync2_q;
          state_d   = CFG_LO;
        end else if (rda) begin
          state_d = READ;
        end
      end
      READ: begin
        rx_byte_d = databus;
        state_d   = WAIT_TBR;
      end
      WAIT_TBR: if (tbr) state_d = WRITE;
      WRITE: begin
        last_byte_d = echo_byte;
        echo_cnt_d  = echo_cnt_q + 8'd1;
        state_d     = IDLE;
      end
      default: state_d = CFG_LO;
    endcase
  end

  // Outputs are gated by rst_n so the bus is released the instant reset asserts.
  always_comb begin
    iocs   = 1'b0;
    iorw   = 1'b1;
    ioaddr = 2'b00;
    dout   = 8'h00;
    case (state_q)
      CFG_LO: begin
        iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b10; dout = div_sel[7:0];
      end
      CFG_HI: begin
        iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b11; dout = div_sel[15:8];
      end
      READ:  iocs = 1'b1;
      WRITE: begin
        iocs = 1'b1; iorw = 1'b0; dout = echo_byte;
      end
      default: ;
    endcase
    if (!rst_n) begin
      iocs = 1'b0;
      iorw = 1'b1;
    end
  end

  assign drive     = iocs & ~iorw;
  assign databus   = drive ? dout : 8'bzzzz_zzzz;
  assign last_byte = last_byte_q;
  assign echo_cnt  = echo_cnt_q;

endmodule

// File: tb/tb_spart_driver.sv
// Scoreboard bench for spart_driver: stimulus pushes expected bus transactions, a monitor pops and compares.
module tb_spart_driver;
  logic       clk;
  logic       rst_n;
  logic [1:0] br_cfg;
  logic       rda;
  logic       tbr;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic [7:0] last_byte;
  logic [7:0] echo_cnt;

  logic [7:0] rx_data;
  int checks;
  int errors;
  int cyc;
  logic [10:0] sbq[$];

  logic [7:0] m_cnt;
  logic [7:0] m_last;
  logic [1:0] m_cfg;

  spart_driver dut (
    .clk(clk), .rst_n(rst_n), .br_cfg(br_cfg), .rda(rda), .tbr(tbr),
    .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus),
    .last_byte(last_byte), .echo_cnt(echo_cnt)
  );

  // SPART side: drives the RX byte only when the controller reads the data register.
  assign databus = (iocs && iorw && ioaddr == 2'b00) ? rx_data : 8'bzzzz_zzzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] div_of(input logic [1:0] c);
    case (c)
      2'b00:   div_of = 16'h028A;
      2'b01:   div_of = 16'h0144;
      2'b10:   div_of = 16'h00A2;
      default: div_of = 16'h0050;
    endcase
  endfunction

  function automatic logic [7:0] up(input logic [7:0] b);
`ifdef SPART_DRV_UPPERCASE_EN
    up = (b >= "a" && b <= "z") ? b - 8'd32 : b;
`else
    up = b;
`endif
  endfunction

  task automatic push_cfg(input logic [1:0] c);
    logic [15:0] d;
    d = div_of(c);
    sbq.push_back({1'b0, 2'b10, d[7:0]});
    sbq.push_back({1'b0, 2'b11, d[15:8]});
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %02h required %02h", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Monitor: every bus cycle must match the oldest expected transaction.
  always @(negedge clk) begin
    logic [10:0] e;
    logic [10:0] got;
    if (rst_n && iocs) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_txn: got rw=%0b addr=%0d data=%02h required none", iorw, ioaddr, databus);
      end else begin
        e = sbq.pop_front();
        got = {iorw, ioaddr, (iorw ? e[7:0] : databus)};
        if (got !== e) begin
          errors++;
          $display("FAIL bus_txn: got rw=%0b addr=%0d data=%02h required rw=%0b addr=%0d data=%02h",
                   got[10], got[9:8], got[7:0], e[10], e[9:8], e[7:0]);
        end
      end
    end
  end

  task automatic wait_txn(input logic rw, output int c, output bit ok);
    ok = 1'b0;
    c = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (rst_n && iocs && iorw == rw && ioaddr == 2'b00) begin
        ok = 1'b1;
        c = cyc;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: got none required a bus cycle", rw ? "read" : "write");
    end
  endtask

  task automatic do_reset(input int hold);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check8("iocs_in_reset", {7'd0, iocs}, 8'h00);
    check8("iorw_in_reset", {7'd0, iorw}, 8'h01);
    check8("cnt_in_reset", echo_cnt, 8'h00);
    check8("last_in_reset", last_byte, 8'h00);
    m_cnt = 8'h00;
    m_last = 8'h00;
    sbq.delete();
    push_cfg(2'b00);
    if (br_cfg != 2'b00) push_cfg(br_cfg);
    m_cfg = br_cfg;
    repeat (hold) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  task automatic change_cfg(input logic [1:0] c);
    @(posedge clk);
    #1 br_cfg = c;
    if (c != m_cfg) push_cfg(c);
    m_cfg = c;
    repeat (8) @(posedge clk);
  endtask

  // One echo: tdly cycles of tbr=0 after the read; optional br_cfg change while waiting; optional reset abort.
  task automatic echo(input logic [7:0] b, input int tdly, input bit chg, input logic [1:0] nc, input bit abort);
    int s, rc, wc, tc;
    bit ok;
    @(posedge clk);
    #1;
    s = cyc;
    rx_data = b;
    tbr = (tdly == 0);
    rda = 1'b1;
    sbq.push_back({1'b1, 2'b00, 8'h00});
    if (!abort) sbq.push_back({1'b0, 2'b00, up(b)});
    wait_txn(1'b1, rc, ok);
    rda = 1'b0;
    if (!ok) return;
    check_int("rda_to_read", rc - s, 1);
    if (chg) begin
      br_cfg = nc;
      if (nc != m_cfg) push_cfg(nc);
      m_cfg = nc;
    end
    if (abort) begin
      repeat (3) @(posedge clk);
      do_reset(2);
      return;
    end
    tc = rc;
    if (tdly > 0) begin
      repeat (tdly) @(negedge clk);
      #1 tbr = 1'b1;
      tc = cyc;
    end
    wait_txn(1'b0, wc, ok);
    if (!ok) return;
    if (tdly == 0) check_int("read_to_write", wc - rc, 2);
    else           check_int("tbr_to_write", wc - tc, 1);
    m_cnt = m_cnt + 8'd1;
    m_last = up(b);
    @(posedge clk);
    #1;
    check8("echo_cnt", echo_cnt, m_cnt);
    check8("last_byte", last_byte, m_last);
    repeat (8) @(posedge clk);
  endtask

  initial begin
    logic [7:0] b;
    checks = 0;
    errors = 0;
    cyc = 0;
    rst_n = 1'b1;
    br_cfg = 2'b00;
    rda = 1'b0;
    tbr = 1'b1;
    rx_data = 8'h00;
    m_cfg = 2'b00;
    m_cnt = 8'h00;
    m_last = 8'h00;

    do_reset(3);
    check8("idle_iocs", {7'd0, iocs}, 8'h00);

    echo(8'h55, 0, 1'b0, 2'b00, 1'b0);
    echo(8'h3C, 50, 1'b0, 2'b00, 1'b0);
    echo(8'hA7, 10, 1'b1, 2'b11, 1'b0);
    echo(8'h61, 0, 1'b0, 2'b00, 1'b0);
    echo(8'h7B, 2, 1'b0, 2'b00, 1'b0);
    echo(8'h7A, 0, 1'b0, 2'b00, 1'b0);
    echo(8'h60, 1, 1'b0, 2'b00, 1'b0);

    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 3) == 0) change_cfg(2'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) b = 8'($urandom_range(8'h5E, 8'h7E));
      else                           b = 8'($urandom_range(0, 255));
      echo(b, int'($urandom_range(0, 6)), 1'b0, 2'b00, 1'b0);
    end

    change_cfg(2'b00);
    echo(8'h42, 20, 1'b0, 2'b00, 1'b1);
    echo(8'h6D, 0, 1'b0, 2'b00, 1'b0);

    change_cfg(2'b10);
    do_reset(2);
    echo(8'h31, 3, 1'b0, 2'b00, 1'b0);

    repeat (10) @(posedge clk);
    check_int("scoreboard_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
